// File: rtl/lmsm_engine_if.sv
// Memory and register-file side bus of the load/store-multiple sequencer.
interface lmsm_engine_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RA_W   = 3
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [RA_W-1:0]   rf_radd;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_wen;
  logic [RA_W-1:0]   rf_wadd;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, rf_radd, rf_wen, rf_wadd, rf_wdata,
    input  mem_ack, mem_rdata, rf_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, rf_radd, rf_wen, rf_wadd, rf_wdata,
    output mem_ack, mem_rdata, rf_rdata
  );
endinterface

// File: rtl/lmsm_engine.sv
// Load-multiple/store-multiple sequencer: one memory access per set mask bit, lowest first.
// Optional base-register writeback enabled by defining LMSM_WRITEBACK_EN.
module lmsm_engine #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned NREGS  = 8,
  localparam int unsigned RA_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              proc_rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NREGS-1:0]  reg_mask,
  input  logic [RA_W-1:0]   base_reg,
  output logic              busy,
  output logic              done,
  lmsm_engine_if.master     bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WB, DONE} state_t;

`ifdef LMSM_WRITEBACK_EN
  localparam state_t AFTER_XFER = WB;
`else
  localparam state_t AFTER_XFER = DONE;
`endif

  state_t            state;
  logic [NREGS-1:0]  mask_q;
  logic [ADDR_W-1:0] cur_addr;
  logic              store_q;
  logic [RA_W-1:0]   idx;
  logic [NREGS-1:0]  mask_rem;
  logic              ld_wr;
  logic              in_wb;

`ifdef LMSM_WRITEBACK_EN
  logic [RA_W-1:0]   breg_q;
`else
  logic              unused_base_reg;
  assign unused_base_reg = ^base_reg;
`endif

  // Lowest set bit of the remaining mask.
  always_comb begin
    idx = '0;
    for (int i = int'(NREGS) - 1; i >= 0; i--) begin
      if (mask_q[i]) idx = RA_W'(i);
    end
  end

  assign mask_rem = mask_q & ~(NREGS'(1) << idx);

  always_ff @(posedge clk or posedge proc_rst) begin
    if (proc_rst) begin
      state    <= IDLE;
      mask_q   <= '0;
      cur_addr <= '0;
      store_q  <= 1'b0;
`ifdef LMSM_WRITEBACK_EN
      breg_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            store_q  <= is_store;
            mask_q   <= reg_mask;
            cur_addr <= base_addr;
`ifdef LMSM_WRITEBACK_EN
            breg_q   <= base_reg;
`endif
            state    <= (reg_mask == '0) ? AFTER_XFER : ACCESS;
          end
        end
        ACCESS: begin
          // Without an ack everything holds, giving clean wait states.
          if (bus.mem_ack) begin
            mask_q   <= mask_rem;
            cur_addr <= cur_addr + ADDR_W'(1);
            if (mask_rem == '0) state <= AFTER_XFER;
          end
        end
        WB:      state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state register so reset clears them asynchronously.
  assign busy          = (state == ACCESS) || (state == WB);
  assign done          = (state == DONE);
  assign bus.mem_req   = (state == ACCESS);
  assign bus.mem_we    = bus.mem_req & store_q;
  assign bus.mem_addr  = cur_addr;
  assign bus.mem_wdata = bus.mem_req ? bus.rf_rdata : '0;
  assign bus.rf_radd   = bus.mem_req ? idx : '0;

  assign ld_wr = bus.mem_req & bus.mem_ack & ~store_q;
`ifdef LMSM_WRITEBACK_EN
  assign in_wb = (state == WB);
  assign bus.rf_wen   = ld_wr | in_wb;
  assign bus.rf_wadd  = ld_wr ? idx : (in_wb ? breg_q : '0);
  assign bus.rf_wdata = ld_wr ? bus.mem_rdata : (in_wb ? DATA_W'(cur_addr) : '0);
`else
  assign in_wb = 1'b0;
  assign bus.rf_wen   = ld_wr | in_wb;
  assign bus.rf_wadd  = ld_wr ? idx : '0;
  assign bus.rf_wdata = ld_wr ? bus.mem_rdata : '0;
`endif

endmodule
